// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment patterns, special codes and the
// capture FSM state encoding used by the display driver and scan decoder.
package seg_pkg;

  // Segment patterns for seg_data[7:1] = {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes for patterns that are not a decimal digit.
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  // Capture FSM: TRACK waits for a stable sample, HOLD waits for a change.
  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of a 7-segment pattern back to its BCD code.
// Blank maps to CODE_BLANK; anything unrecognised maps to CODE_ERR + invalid.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       invalid
);

  // Pattern lookup; unknown patterns are flagged rather than guessed.
  always_comb begin
    invalid = 1'b0;
    case (pattern)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code    = CODE_ERR;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Scan-side decoder for the multiplexed 7-segment bus: filters scan glitches,
// decodes each stable pattern and assembles all positions into a frame.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int NUM_DIGITS    = 8
) (
  input  logic                      clk_1000hz,
  input  logic                      reset,
  input  logic [2:0]                digit,
  input  logic [7:0]                seg_data,
  output logic [4*NUM_DIGITS-1:0]   frame_data,
  output logic [NUM_DIGITS-1:0]     frame_dp,
  output logic                      frame_valid,
  output logic                      err_pulse,
  output logic [7:0]                err_count
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

  logic [10:0]                 sample;
  logic [10:0]                 prev;
  logic                        same;
  logic [3:0]                  cnt;
  logic [3:0]                  cnt_next;
  scan_state_t                 state;
  logic                        capture;
  logic [3:0]                  code;
  logic                        invalid;
  logic [NUM_DIGITS-1:0]       digit_bit;
  logic [NUM_DIGITS-1:0]       mask;
  logic [NUM_DIGITS-1:0]       mask_base;
  logic [NUM_DIGITS-1:0]       mask_next;
  logic                        complete;
  logic                        complete_next;
  logic [NUM_DIGITS-1:0][3:0]  slot_code;
  logic [NUM_DIGITS-1:0]       slot_dp;

  assign sample = {digit, seg_data};
  assign same   = (sample == prev);

  seg7_to_bcd u_decode (
    .pattern (seg_data[7:1]),
    .code    (code),
    .invalid (invalid)
  );

  // Stability count, capture decision and next seen-mask.
  always_comb begin
    cnt_next  = same ? (cnt + 4'd1) : 4'd1;
    // In HOLD a steady sample never captures; a change restarts the count,
    // which captures immediately only when one sample is enough.
    capture   = ((state == TRACK) || !same) && (cnt_next == STABLE_CNT);
    digit_bit = '0;
    digit_bit[digit] = 1'b1;
    // A completed frame clears the mask; a capture in that same cycle
    // already belongs to the next frame.
    mask_base = complete ? '0 : mask;
    if (capture) begin
      mask_next = mask_base | digit_bit;
    end else begin
      mask_next = mask_base;
    end
    complete_next = capture && (&(mask_base | digit_bit));
  end

  // Input history register and TRACK/HOLD capture FSM.
  always_ff @(posedge clk_1000hz or posedge reset) begin
    if (reset) begin
      prev  <= 11'h000;
      cnt   <= 4'd0;
      state <= TRACK;
    end else begin
      prev <= sample;
      case (state)
        TRACK: begin
          cnt <= cnt_next;
          if (capture) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!same) begin
            cnt   <= 4'd1;
            state <= capture ? HOLD : TRACK;
          end
        end
        default: begin
          cnt   <= 4'd0;
          state <= TRACK;
        end
      endcase
    end
  end

  // Capture slots, seen-mask and frame-complete flag.
  always_ff @(posedge clk_1000hz or posedge reset) begin
    if (reset) begin
      slot_code <= '0;
      slot_dp   <= '0;
      mask      <= '0;
      complete  <= 1'b0;
    end else begin
      if (capture) begin
        slot_code[digit] <= code;
        slot_dp[digit]   <= seg_data[0];
      end
      mask     <= mask_next;
      complete <= complete_next;
    end
  end

  // Registered frame outputs and error reporting.
  always_ff @(posedge clk_1000hz or posedge reset) begin
    if (reset) begin
      frame_data  <= '0;
      frame_dp    <= '0;
      frame_valid <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      frame_valid <= complete;
      if (complete) begin
        frame_data <= slot_code;
        frame_dp   <= slot_dp;
      end
      err_pulse <= capture && invalid;
      if (capture && invalid && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: expected frames go into a queue as the
// scans are issued; a negedge monitor pops and compares on every frame_valid.
module tb_seg_scan_decoder;

  logic        clk_1000hz;
  logic        reset;
  logic [2:0]  digit;
  logic [7:0]  seg_data;
  logic [31:0] frame_data;
  logic [7:0]  frame_dp;
  logic        frame_valid;
  logic        err_pulse;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  int err_pulses_seen = 0;
  logic [39:0] exp_q[$];

  seg_scan_decoder dut (
    .clk_1000hz  (clk_1000hz),
    .reset       (reset),
    .digit       (digit),
    .seg_data    (seg_data),
    .frame_data  (frame_data),
    .frame_dp    (frame_dp),
    .frame_valid (frame_valid),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  initial clk_1000hz = 1'b0;
  always #5 clk_1000hz = ~clk_1000hz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one position/pattern for n rising edges, then settle past the edge.
  task automatic dwell(input logic [2:0] d, input logic [7:0] s, input int n);
    digit    = d;
    seg_data = s;
    repeat (n) @(posedge clk_1000hz);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk_1000hz);
    check({tag, " frame_data"}, frame_data, 32'h0);
    check({tag, " frame_dp"}, {24'h0, frame_dp}, 32'h0);
    check({tag, " frame_valid"}, {31'h0, frame_valid}, 32'h0);
    check({tag, " err_pulse"}, {31'h0, err_pulse}, 32'h0);
    check({tag, " err_count"}, {24'h0, err_count}, 32'h0);
  endtask

  // Scoreboard monitor: every frame_valid must match the oldest expectation.
  always @(negedge clk_1000hz) begin
    if (!reset && err_pulse) err_pulses_seen++;
    if (!reset && frame_valid) begin
      logic [39:0] e;
      frames_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got data %h dp %h expected no frame", frame_data, frame_dp);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", frame_data, e[39:8]);
        check("frame_dp", {24'h0, frame_dp}, {24'h0, e[7:0]});
      end
    end
  end

  logic [7:0] scan1 [8] = '{8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE};

  initial begin
    reset    = 1'b1;
    digit    = 3'd0;
    seg_data = 8'h00;
    check_reset_outputs("init");
    @(posedge clk_1000hz); #1;
    reset = 1'b0;

    // Stable scan with a precise frame_valid latency check on position 7.
    exp_q.push_back({32'h87654321, 8'h00});
    for (int i = 0; i < 7; i++) dwell(3'(i), scan1[i], 5);
    dwell(3'd7, 8'hFE, 3);
    check("valid_before", {31'h0, frame_valid}, 32'h0);
    dwell(3'd7, 8'hFE, 1);
    check("valid_pulse", {31'h0, frame_valid}, 32'h1);
    dwell(3'd7, 8'hFE, 1);
    check("valid_drop", {31'h0, frame_valid}, 32'h0);
    check("err_count_clean", {24'h0, err_count}, 32'h0);

    // Glitch reject: 2-cycle 0 on position 2 must not survive.
    exp_q.push_back({32'h87654121, 8'h00});
    dwell(3'd0, 8'h60, 5);
    dwell(3'd1, 8'hDA, 5);
    dwell(3'd2, 8'hFC, 2);
    dwell(3'd2, 8'h60, 4);
    for (int i = 3; i < 8; i++) dwell(3'(i), scan1[i], 5);

    // Decimal points and blank.
    exp_q.push_back({32'h0000000F, 8'hFF});
    dwell(3'd0, 8'h01, 5);
    for (int i = 1; i < 8; i++) dwell(3'(i), 8'hFD, 5);

    // Invalid pattern on position 4.
    exp_q.push_back({32'h000E0000, 8'h00});
    for (int i = 0; i < 8; i++) dwell(3'(i), (i == 4) ? 8'h92 : 8'hFC, 5);
    dwell(3'd0, 8'hFC, 2);
    check("err_count_one", {24'h0, err_count}, 32'h1);
    check("err_pulses_one", 32'(err_pulses_seen), 32'd1);

    // 300 more invalid captures alternating positions 5 and 4.
    for (int i = 0; i < 150; i++) begin
      dwell(3'd5, 8'h92, 3);
      dwell(3'd4, 8'h92, 3);
    end
    dwell(3'd4, 8'h92, 2);
    check("err_count_sat", {24'h0, err_count}, 32'hFF);
    check("err_pulses_301", 32'(err_pulses_seen), 32'd301);

    // Partial scan, reset mid-dwell, then a full scan gives one frame.
    for (int i = 0; i < 6; i++) dwell(3'(i), scan1[i], 5);
    dwell(3'd6, 8'hE0, 2);
    reset = 1'b1;
    check_reset_outputs("midreset");
    @(posedge clk_1000hz); #1;
    reset = 1'b0;
    dwell(3'd6, 8'hE0, 2);
    exp_q.push_back({32'h87654321, 8'h00});
    for (int i = 0; i < 8; i++) dwell(3'(i), scan1[i], 5);

    // Position 3 recaptured as 9 before the frame completes.
    exp_q.push_back({32'h87659321, 8'h00});
    for (int i = 0; i < 6; i++) dwell(3'(i), (i == 3) ? 8'hB6 : scan1[i], 5);
    dwell(3'd3, 8'hF6, 5);
    dwell(3'd6, 8'hE0, 5);
    dwell(3'd7, 8'hFE, 5);

    // Bounded drain of any outstanding expectation.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_1000hz);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("frame_total", 32'(frames_seen), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver. It samples the scanned digit-select and segment bus and filters scan glitches.
- It decodes each stable segment pattern back to a BCD code and assembles all 8 positions into a frame.
- Used as an on-chip loopback checker and as a self-checking monitor in display benches. Sits on the clk_1000hz domain beside the display driver.

Parameters:
- STABLE_CYCLES, 3: consecutive identical samples of {digit, seg_data} required before a capture (1..15).
- NUM_DIGITS, 8: scan positions per frame; fixed by the 3-bit digit bus.

Ports:
- clk_1000hz  input  1  scan clock; the single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- digit  input  3  binary index of the currently driven position, 0..7.
- seg_data  input  8  segment pattern, active-high: [7:1]=a,b,c,d,e,f,g; [0]=dp.
- frame_data  output  32  decoded codes; nibble i = position i.
- frame_dp  output  8  decimal-point bit per position.
- frame_valid  output  1  1-cycle pulse when frame_data/frame_dp update.
- err_pulse  output  1  1-cycle pulse on capture of an undecodable pattern.
- err_count  output  8  saturating count of undecodable captures.

Behaviour:
- Reset (async assert, sync-safe deassert by design):
  - frame_data=32'h0 and frame_dp=8'h0.
  - frame_valid=0, err_pulse=0, err_count=0.
  - Seen-mask=0, capture regs=0, FSM=TRACK, stability counter=0.
- Input sampling: {digit, seg_data} is registered once (prev). The stability counter compares each new sample to prev.
- FSM TRACK:
  - Sample equals prev: the counter increments.
  - Sample differs: the counter reloads to 1.
  - Counter reaches STABLE_CYCLES: capture in that cycle and go to HOLD.
- FSM HOLD:
  - No capture while the sample stays equal to prev.
  - Any change returns to TRACK with the counter at 1.
- Capture latency: with STABLE_CYCLES=3, capture occurs on the 3rd consecutive equal sample. Frame outputs update one cycle later.
- Decode of seg_data[7:1] (dp ignored for decode):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9.
  - 00 (blank) → 4'hF.
  - Any other pattern → 4'hE, raising err_pulse for 1 cycle and incrementing err_count (saturates at 255).
- Capture effect: code and dp are written to capture slot [digit], and seen-mask bit [digit] is set. Re-capturing the same position before the frame completes overwrites the slot.
- Frame completion: when a capture makes the seen-mask all ones (including the completing capture):
  - Next cycle, frame_data/frame_dp load from the capture slots.
  - frame_valid pulses and the seen-mask clears to 0.
- Capture coinciding with a mask clear: it counts toward the next frame.
- frame_data holds its value between frames.
- Reset mid-frame discards partial captures. No frame_valid until 8 fresh positions are seen.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package seg_pkg holds:
  - Segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - Code constants CODE_BLANK=4'hF and CODE_ERR=4'hE.
  - FSM state encoding TRACK/HOLD.
- The display driver and this block both use seg_pkg patterns.
- One sub-module, seg7_to_bcd: purely combinational decode, pattern[6:0] → code[3:0] plus invalid flag. The FSM, counters and frame assembly stay in the top.

Test Plan:
- Stable scan: drive positions 0..7 in turn, each held 5 cycles, with patterns for digits 1,2,3,4,5,6,7,8 (seg_data 60,DA,F2,66,B6,BE,E0,FE) → one frame_valid pulse, frame_data=32'h87654321, frame_dp=8'h00, err_count=0.
- Glitch reject: hold position 2 for 2 cycles with 8'hFC, then switch to 8'h60 held 4 cycles → only code 1 is captured for position 2; no capture of 0.
- DP and blank: position 0 = 8'h01 (blank + dp), others 8'hFD (0 + dp) → frame_data=32'h0000000F, frame_dp=8'hFF.
- Invalid pattern: position 4 = 8'h92 → capture code E, err_pulse once, err_count=1. Hold 300 more invalid captures → err_count saturates at 255.
- Incomplete/reset: scan positions 0..6 only, assert reset for 1 cycle mid-dwell, then full scan → exactly one frame_valid (after the post-reset scan), all outputs 0 during reset.
- Repeat overwrite: position 3 captured as 5, then later as 9 before position 7 appears → completed frame nibble 3 = 9.
